// File: rtl/icache_responder.sv
// rtl/icache_responder.sv - direct-mapped blocking instruction cache responder
//
// Purpose:
//   I-cache side of the fetch req/rsp interface. Each accepted fetch returns
//   one 32-bit instruction word. Hits answer on the next cycle; a miss refills
//   the whole line from the memory port and then answers from the refill.
//
// Ports:
//   clk, rst          clock (rising edge) and asynchronous active-low reset
//   ic_req_*          fetch request (valid/ready/addr); addr[1:0] ignored
//   ic_rsp_valid/data one-cycle response pulse, no backpressure
//   ic_kill_i         fetch redirect, discards any pending response
//   ic_inv_i          invalidate every line (fence.i), single-cycle pulse
//   mem_req_*         line refill request (valid/ready/line-aligned addr)
//   mem_rsp_*         refill beats, ascending word order, no backpressure
//   stat_hits/misses  only when ICACHE_STATS_EN is defined
//
// Configuration:
//   ICACHE_STATS_EN   adds 32-bit accepted-hit / accepted-miss counters
module icache_responder #(
  parameter int SETS       = 64,
  parameter int LINE_WORDS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ic_req_valid,
  output logic        ic_req_ready,
  input  logic [31:0] ic_req_addr,
  output logic        ic_rsp_valid,
  output logic [31:0] ic_rsp_data,
  input  logic        ic_kill_i,
  input  logic        ic_inv_i,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_data
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0] stat_hits,
  output logic [31:0] stat_misses
`endif
);

  localparam int OFF_W = $clog2(LINE_WORDS);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = 30 - OFF_W - IDX_W;

  localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(LINE_WORDS - 1);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_MISS_REQ = 2'd1;
  localparam logic [1:0] S_REFILL   = 2'd2;
  localparam logic [1:0] S_RESP     = 2'd3;

  // Storage: valid bits are reset, tag and data arrays are not.
  logic [SETS-1:0]  valid_q;
  logic [TAG_W-1:0] tag_mem  [SETS];
  logic [31:0]      data_mem [SETS][LINE_WORDS];

  logic [1:0]       state_q;
  logic [29:0]      miss_waddr_q;  // word address of the request being refilled
  logic [OFF_W-1:0] beat_q;
  logic             drop_q;        // response of the in-flight miss is discarded
  logic             inv_pend_q;    // invalidate seen while busy, applied on return to IDLE
  logic             hit_rsp_q;     // a hit was accepted last cycle
  logic [31:0]      rsp_data_q;

  // Request address fields
  logic [IDX_W-1:0] req_idx;
  logic [OFF_W-1:0] req_off;
  logic [TAG_W-1:0] req_tag;
  logic [1:0]       unused_addr_lsbs;

  assign req_idx          = ic_req_addr[OFF_W+2 +: IDX_W];
  assign req_off          = ic_req_addr[2 +: OFF_W];
  assign req_tag          = ic_req_addr[31 -: TAG_W];
  assign unused_addr_lsbs = ic_req_addr[1:0];

  // Latched miss address fields
  logic [IDX_W-1:0] miss_idx;
  logic [OFF_W-1:0] miss_off;
  logic [TAG_W-1:0] miss_tag;

  assign miss_idx = miss_waddr_q[OFF_W +: IDX_W];
  assign miss_off = miss_waddr_q[OFF_W-1:0];
  assign miss_tag = miss_waddr_q[29 -: TAG_W];

  // Lookup and accept
  logic in_idle;
  logic accept;
  logic lookup_hit;
  logic accept_hit;
  logic accept_miss;
  logic refill_beat;
  logic refill_last;

  assign in_idle = (state_q == S_IDLE);
  assign accept  = ic_req_valid & in_idle & ~ic_kill_i;

  // A same-cycle invalidate forces a miss so the request never sees a line
  // that is being cleared on this edge.
  assign lookup_hit  = valid_q[req_idx] & (tag_mem[req_idx] == req_tag) & ~ic_inv_i;
  assign accept_hit  = accept & lookup_hit;
  assign accept_miss = accept & ~lookup_hit;

  assign refill_beat = (state_q == S_REFILL) & mem_rsp_valid;
  assign refill_last = refill_beat & (beat_q == LAST_BEAT);

  // Outputs
  assign ic_req_ready  = in_idle;
  assign mem_req_valid = (state_q == S_MISS_REQ);
  assign mem_req_addr  = {miss_waddr_q[29:OFF_W], {(OFF_W+2){1'b0}}};
  assign ic_rsp_data   = rsp_data_q;

  // A kill arriving while the response is on the wire still discards it.
  assign ic_rsp_valid = (hit_rsp_q | ((state_q == S_RESP) & ~drop_q)) & ~ic_kill_i;

  // Control state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      valid_q      <= '0;
      miss_waddr_q <= '0;
      beat_q       <= '0;
      drop_q       <= 1'b0;
      inv_pend_q   <= 1'b0;
      hit_rsp_q    <= 1'b0;
      rsp_data_q   <= '0;
    end else begin
      hit_rsp_q <= accept_hit;

      case (state_q)
        S_IDLE: begin
          if (ic_inv_i) begin
            valid_q <= '0;
          end
          if (accept_hit) begin
            rsp_data_q <= data_mem[req_idx][req_off];
          end
          if (accept_miss) begin
            miss_waddr_q <= ic_req_addr[31:2];
            beat_q       <= '0;
            state_q      <= S_MISS_REQ;
          end
        end

        S_MISS_REQ: begin
          if (ic_kill_i) begin
            drop_q <= 1'b1;
          end
          if (ic_inv_i) begin
            inv_pend_q <= 1'b1;
          end
          if (mem_req_ready) begin
            state_q <= S_REFILL;
          end
        end

        S_REFILL: begin
          if (ic_kill_i) begin
            drop_q <= 1'b1;
          end
          if (ic_inv_i) begin
            inv_pend_q <= 1'b1;
          end
          if (refill_beat) begin
            // Capture the requested word as it streams past so RESP needs
            // no array read.
            if (beat_q == miss_off) begin
              rsp_data_q <= mem_rsp_data;
            end
            beat_q <= beat_q + OFF_W'(1);
          end
          if (refill_last) begin
            valid_q[miss_idx] <= 1'b1;
            state_q           <= S_RESP;
          end
        end

        S_RESP: begin
          // Pending invalidate also wipes the line just installed.
          if (inv_pend_q | ic_inv_i) begin
            valid_q <= '0;
          end
          drop_q     <= 1'b0;
          inv_pend_q <= 1'b0;
          state_q    <= S_IDLE;
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Tag and data arrays
  always_ff @(posedge clk) begin
    if (refill_beat) begin
      data_mem[miss_idx][beat_q] <= mem_rsp_data;
    end
    if (refill_last) begin
      tag_mem[miss_idx] <= miss_tag;
    end
  end

`ifdef ICACHE_STATS_EN
  // Counted at accept, so a later kill does not remove the event.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_hits   <= '0;
      stat_misses <= '0;
    end else begin
      if (accept_hit) begin
        stat_hits <= stat_hits + 32'd1;
      end
      if (accept_miss) begin
        stat_misses <= stat_misses + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_icache_responder.sv
// tb/tb_icache_responder.sv - self-checking bench for icache_responder
module tb_icache_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ic_req_valid = 1'b0;
  logic        ic_req_ready;
  logic [31:0] ic_req_addr = '0;
  logic        ic_rsp_valid;
  logic [31:0] ic_rsp_data;
  logic        ic_kill_i = 1'b0;
  logic        ic_inv_i = 1'b0;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b0;
  logic [31:0] mem_req_addr;
  logic        mem_rsp_valid = 1'b0;
  logic [31:0] mem_rsp_data = '0;
`ifdef ICACHE_STATS_EN
  logic [31:0] stat_hits;
  logic [31:0] stat_misses;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  icache_responder dut (
    .clk          (clk),
    .rst          (rst),
    .ic_req_valid (ic_req_valid),
    .ic_req_ready (ic_req_ready),
    .ic_req_addr  (ic_req_addr),
    .ic_rsp_valid (ic_rsp_valid),
    .ic_rsp_data  (ic_rsp_data),
    .ic_kill_i    (ic_kill_i),
    .ic_inv_i     (ic_inv_i),
    .mem_req_valid(mem_req_valid),
    .mem_req_ready(mem_req_ready),
    .mem_req_addr (mem_req_addr),
    .mem_rsp_valid(mem_rsp_valid),
    .mem_rsp_data (mem_rsp_data)
`ifdef ICACHE_STATS_EN
    ,
    .stat_hits    (stat_hits),
    .stat_misses  (stat_misses)
`endif
  );

  // Reference model: which line each set holds, plus backing memory contents.
  bit          ref_valid [64];
  logic [21:0] ref_tag   [64];

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (a[31:4] == 28'h10) return 32'hA0 + {30'd0, a[3:2]};
    return {a[15:2], 2'b11, a[31:16]} ^ 32'h3C5A_96E1;
  endfunction

  function automatic bit ref_hit(input logic [31:0] a);
    return ref_valid[a[9:4]] && (ref_tag[a[9:4]] == a[31:10]);
  endfunction

  function automatic void ref_fill(input logic [31:0] a);
    ref_valid[a[9:4]] = 1'b1;
    ref_tag[a[9:4]]   = a[31:10];
  endfunction

  function automatic void ref_clear();
    for (int i = 0; i < 64; i++) ref_valid[i] = 1'b0;
  endfunction

  typedef struct {
    bit          rsp_seen;
    logic [31:0] rsp_data;
    bit          mreq_seen;
    logic [31:0] mreq_addr;
    int          lat;
    bit          timeout;
    bit          unstable;
  } fres_t;

  // One fetch plus the memory side it provokes. kill_beat/inv_beat >= 0 pulse
  // on that refill beat; kill_beat == -2 kills the cycle after accept;
  // inv_beat == -2 invalidates in the request cycle. rnd adds memory stalls.
  task automatic fetch(input logic [31:0] addr, input int kill_beat, input int inv_beat,
                       input bit rnd, output fres_t r);
    int  cyc;
    int  beat;
    int  post;
    bit  hs;
    bit  done;
    logic [31:0] line;
    r = '{0, 0, 0, 0, 0, 0, 0};
    beat = 0; post = 0; hs = 0; done = 0;
    line = {addr[31:4], 4'b0};
    @(negedge clk);
    cyc = 0;
    while (!ic_req_ready && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    if (!ic_req_ready) begin
      r.timeout = 1;
      return;
    end
    ic_req_valid = 1'b1;
    ic_req_addr  = addr;
    ic_inv_i     = (inv_beat == -2);
    for (cyc = 1; cyc <= 200 && !done; cyc++) begin
      @(negedge clk);
      ic_req_valid  = 1'b0;
      ic_req_addr   = $urandom;
      ic_kill_i     = (kill_beat == -2) && (cyc == 1);
      ic_inv_i      = 1'b0;
      mem_rsp_valid = 1'b0;
      mem_rsp_data  = $urandom;
      mem_req_ready = rnd ? 1'($urandom_range(0, 2) != 0) : 1'b1;
      if (hs && beat < 4 && (!rnd || $urandom_range(0, 3) != 0)) begin
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = mem_rd(line + 32'(4 * beat));
        if (beat == kill_beat) ic_kill_i = 1'b1;
        if (beat == inv_beat)  ic_inv_i  = 1'b1;
        beat++;
      end
      #1;
      if (mem_req_valid) begin
        if (r.mreq_seen && mem_req_addr !== r.mreq_addr) r.unstable = 1;
        if (!r.mreq_seen) begin
          r.mreq_seen = 1;
          r.mreq_addr = mem_req_addr;
        end
        if (mem_req_ready) hs = 1;
      end
      if (ic_rsp_valid) begin
        r.rsp_seen = 1;
        r.rsp_data = ic_rsp_data;
        r.lat      = cyc;
        done       = 1;
      end
      if (beat == 4) post++;
      if (post >= 3) done = 1;
      if (!r.mreq_seen && cyc >= 2) done = 1;
    end
    if (!done) r.timeout = 1;
    ic_kill_i = 1'b0;
    ic_inv_i  = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (ic_rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got=%b exp=0", ic_rsp_valid); end
    checks++; if (ic_rsp_data !== 32'h0) begin errors++; $display("FAIL reset_rsp_data got=%h exp=0", ic_rsp_data); end
    checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_mem_req_valid got=%b exp=0", mem_req_valid); end
    checks++; if (mem_req_addr !== 32'h0) begin errors++; $display("FAIL reset_mem_req_addr got=%h exp=0", mem_req_addr); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    checks++; if (ic_req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", ic_req_ready); end
    ref_clear();
  endtask

  task automatic test_cold_miss;
    fres_t r;
    fetch(32'h100, -1, -1, 0, r);
    checks++; if (r.mreq_seen !== 1'b1 || r.mreq_addr !== 32'h100) begin errors++; $display("FAIL cold_mem_req seen=%b addr=%h exp addr=00000100", r.mreq_seen, r.mreq_addr); end
    checks++; if (r.rsp_seen !== 1'b1 || r.rsp_data !== 32'hA0) begin errors++; $display("FAIL cold_rsp seen=%b data=%h exp=000000a0", r.rsp_seen, r.rsp_data); end
    checks++; if (r.lat != 6) begin errors++; $display("FAIL cold_latency got=%0d exp=6", r.lat); end
    ref_fill(32'h100);
    fetch(32'h104, -1, -1, 0, r);
    checks++; if (r.mreq_seen !== 1'b0) begin errors++; $display("FAIL hit_no_mem_req got=%b exp=0", r.mreq_seen); end
    checks++; if (r.rsp_seen !== 1'b1 || r.rsp_data !== 32'hA1 || r.lat != 1) begin errors++; $display("FAIL hit_rsp seen=%b data=%h lat=%0d exp data=000000a1 lat=1", r.rsp_seen, r.rsp_data, r.lat); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] exp_d;
    @(negedge clk);
    ic_req_valid = 1'b1;
    ic_req_addr  = 32'h100;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      if (i < 4) ic_req_addr = 32'h100 + 32'(4 * i);
      else ic_req_valid = 1'b0;
      #1;
      exp_d = mem_rd(32'h100 + 32'(4 * (i - 1)));
      checks++; if (ic_rsp_valid !== 1'b1 || ic_rsp_data !== exp_d || mem_req_valid !== 1'b0 || ic_req_ready !== 1'b1) begin
        errors++; $display("FAIL b2b_beat%0d valid=%b data=%h memreq=%b ready=%b exp data=%h", i, ic_rsp_valid, ic_rsp_data, mem_req_valid, ic_req_ready, exp_d);
      end
    end
  endtask

  task automatic test_conflict;
    fres_t r;
    fetch(32'h500, -1, -1, 0, r);
    checks++; if (r.mreq_seen !== 1'b1 || r.mreq_addr !== 32'h500 || r.rsp_data !== mem_rd(32'h500)) begin errors++; $display("FAIL conflict_500 seen=%b addr=%h data=%h exp addr=00000500 data=%h", r.mreq_seen, r.mreq_addr, r.rsp_data, mem_rd(32'h500)); end
    ref_fill(32'h500);
    fetch(32'h100, -1, -1, 0, r);
    checks++; if (r.mreq_seen !== 1'b1 || r.mreq_addr !== 32'h100 || r.rsp_data !== 32'hA0) begin errors++; $display("FAIL conflict_100 seen=%b addr=%h data=%h exp addr=00000100 data=000000a0", r.mreq_seen, r.mreq_addr, r.rsp_data); end
    ref_fill(32'h100);
  endtask

  task automatic test_kill_refill;
    fres_t r;
    fetch(32'h500, -1, -1, 0, r);
    ref_fill(32'h500);
    fetch(32'h100, 1, -1, 0, r);
    checks++; if (r.mreq_seen !== 1'b1 || r.rsp_seen !== 1'b0 || r.timeout) begin errors++; $display("FAIL kill_refill memreq=%b rsp=%b timeout=%b exp memreq=1 rsp=0", r.mreq_seen, r.rsp_seen, r.timeout); end
    ref_fill(32'h100);
    fetch(32'h108, -1, -1, 0, r);
    checks++; if (r.mreq_seen !== 1'b0 || r.rsp_seen !== 1'b1 || r.rsp_data !== 32'hA2 || r.lat != 1) begin errors++; $display("FAIL kill_then_hit memreq=%b rsp=%b data=%h lat=%0d exp data=000000a2 lat=1", r.mreq_seen, r.rsp_seen, r.rsp_data, r.lat); end
  endtask

  task automatic test_kill_hit;
    fres_t r;
    fetch(32'h10C, -2, -1, 0, r);
    checks++; if (r.rsp_seen !== 1'b0 || r.mreq_seen !== 1'b0) begin errors++; $display("FAIL kill_hit rsp=%b memreq=%b exp rsp=0 memreq=0", r.rsp_seen, r.mreq_seen); end
    fetch(32'h10C, -1, -1, 0, r);
    checks++; if (r.rsp_seen !== 1'b1 || r.rsp_data !== 32'hA3 || r.lat != 1) begin errors++; $display("FAIL kill_hit_after rsp=%b data=%h lat=%0d exp data=000000a3 lat=1", r.rsp_seen, r.rsp_data, r.lat); end
  endtask

  task automatic test_invalidate;
    fres_t r;
    @(negedge clk); ic_inv_i = 1'b1;
    @(negedge clk); ic_inv_i = 1'b0;
    ref_clear();
    fetch(32'h100, -1, -1, 0, r);
    checks++; if (r.mreq_seen !== 1'b1 || r.rsp_data !== 32'hA0) begin errors++; $display("FAIL inv_idle memreq=%b data=%h exp memreq=1 data=000000a0", r.mreq_seen, r.rsp_data); end
    ref_fill(32'h100);
    fetch(32'h140, -1, 2, 0, r);
    checks++; if (r.mreq_seen !== 1'b1 || r.rsp_seen !== 1'b1 || r.rsp_data !== mem_rd(32'h140)) begin errors++; $display("FAIL inv_refill_rsp memreq=%b rsp=%b data=%h exp data=%h", r.mreq_seen, r.rsp_seen, r.rsp_data, mem_rd(32'h140)); end
    ref_fill(32'h140);
    ref_clear();
    fetch(32'h140, -1, -1, 0, r);
    checks++; if (r.mreq_seen !== 1'b1 || r.mreq_addr !== 32'h140) begin errors++; $display("FAIL inv_refill_rerequest memreq=%b addr=%h exp memreq=1 addr=00000140", r.mreq_seen, r.mreq_addr); end
    ref_fill(32'h140);
    fetch(32'h144, -1, -2, 0, r);
    checks++; if (r.mreq_seen !== 1'b1 || r.rsp_data !== mem_rd(32'h144)) begin errors++; $display("FAIL inv_same_cycle memreq=%b data=%h exp memreq=1 data=%h", r.mreq_seen, r.rsp_data, mem_rd(32'h144)); end
    ref_clear();
    ref_fill(32'h140);
  endtask

  task automatic test_reset_mid_refill;
    fres_t r;
    @(negedge clk); ic_inv_i = 1'b1;
    @(negedge clk); ic_inv_i = 1'b0;
    ref_clear();
    ic_req_valid  = 1'b1;
    ic_req_addr   = 32'h100;
    mem_req_ready = 1'b1;
    @(negedge clk);
    ic_req_valid = 1'b0;
    #1;
    checks++; if (mem_req_valid !== 1'b1) begin errors++; $display("FAIL rmr_mem_req got=%b exp=1", mem_req_valid); end
    for (int b = 0; b < 2; b++) begin
      @(negedge clk);
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = mem_rd(32'h100 + 32'(4 * b));
    end
    @(negedge clk);
    rst = 1'b0;
    mem_rsp_data = mem_rd(32'h108);
    #1;
    checks++; if (mem_req_valid !== 1'b0 || ic_rsp_valid !== 1'b0 || ic_req_ready !== 1'b1) begin errors++; $display("FAIL rmr_outputs memreq=%b rsp=%b ready=%b exp 0 0 1", mem_req_valid, ic_rsp_valid, ic_req_ready); end
    @(negedge clk);
    rst = 1'b1;
    mem_rsp_data = 32'hDEAD_BEEF;
    repeat (2) @(negedge clk);
    mem_rsp_valid = 1'b0;
    #1;
    checks++; if (ic_rsp_valid !== 1'b0 || ic_req_ready !== 1'b1 || mem_req_valid !== 1'b0) begin errors++; $display("FAIL rmr_stray rsp=%b ready=%b memreq=%b exp 0 1 0", ic_rsp_valid, ic_req_ready, mem_req_valid); end
    ref_clear();
    fetch(32'h100, -1, -1, 0, r);
    checks++; if (r.mreq_seen !== 1'b1 || r.mreq_addr !== 32'h100 || r.rsp_data !== 32'hA0) begin errors++; $display("FAIL rmr_refetch memreq=%b addr=%h data=%h exp 1 00000100 000000a0", r.mreq_seen, r.mreq_addr, r.rsp_data); end
    ref_fill(32'h100);
  endtask

  task automatic test_random;
    fres_t       r;
    logic [31:0] a;
    bit          exp_miss;
    bit          killed;
    int          kb;
    int          ib;
    for (int n = 0; n < 60; n++) begin
      a = (32'($urandom_range(0, 2)) << 10) | (32'($urandom_range(0, 3)) << 4)
        | (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
      exp_miss = !ref_hit(a);
      kb = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 3)) : -1;
      ib = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 3)) : -1;
      killed = exp_miss && (kb >= 0);
      fetch(a, kb, ib, 1, r);
      checks++; if (r.timeout || r.unstable) begin errors++; $display("FAIL rand%0d_protocol timeout=%b unstable=%b exp 0 0", n, r.timeout, r.unstable); end
      checks++; if (r.mreq_seen !== exp_miss || (exp_miss && r.mreq_addr !== {a[31:4], 4'b0})) begin errors++; $display("FAIL rand%0d_mem_req addr=%h seen=%b memaddr=%h exp seen=%b", n, a, r.mreq_seen, r.mreq_addr, exp_miss); end
      checks++; if (r.rsp_seen !== !killed || (!killed && r.rsp_data !== mem_rd(a))) begin errors++; $display("FAIL rand%0d_rsp addr=%h seen=%b data=%h exp seen=%b data=%h", n, a, r.rsp_seen, r.rsp_data, !killed, mem_rd(a)); end
      if (exp_miss) begin
        ref_fill(a);
        if (ib >= 0) ref_clear();
      end
    end
  endtask

`ifdef ICACHE_STATS_EN
  task automatic test_stats;
    fres_t r;
    @(negedge clk); rst = 1'b0;
    @(negedge clk); rst = 1'b1;
    ref_clear();
    for (int i = 0; i < 4; i++) fetch(32'h200 + 32'(4 * i), -1, -1, 0, r);
    #1;
    checks++; if (stat_misses !== 32'd1 || stat_hits !== 32'd3) begin errors++; $display("FAIL stats misses=%0d hits=%0d exp 1 3", stat_misses, stat_hits); end
  endtask
`endif

  initial begin
    test_reset();
    test_cold_miss();
    test_back_to_back();
    test_conflict();
    test_kill_refill();
    test_kill_hit();
    test_invalidate();
    test_reset_mid_refill();
    test_random();
`ifdef ICACHE_STATS_EN
    test_stats();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
